// File: rtl/fifo_pkg.sv
// Shared widths and skid-buffer state encoding for the FIFO read side.
package fifo_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;
  localparam int CNT_W  = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry output skid buffer: head drives m_data, tail absorbs one
// extra word while the consumer stalls.
module fifo_skid_buf #(
  parameter int DATA_W = fifo_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              full
);
  import fifo_pkg::*;

  buf_state_e        state, state_n;
  logic [DATA_W-1:0] tail, head_n, tail_n;
  logic              xfer;

  assign xfer = m_valid && m_ready;
  assign full = (state == FULL);

  always_comb begin
    state_n = state;
    head_n  = m_data;
    tail_n  = tail;
    unique case (state)
      EMPTY: begin
        if (in_valid) begin
          state_n = HALF;
          head_n  = in_data;
        end
      end
      HALF: begin
        if (in_valid && !xfer) begin
          state_n = FULL;
          tail_n  = in_data;
        end else if (in_valid && xfer) begin
          head_n  = in_data;
        end else if (xfer) begin
          state_n = EMPTY;
        end
      end
      FULL: begin
        if (xfer) begin
          state_n = HALF;
          head_n  = tail;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      m_valid <= 1'b0;
      m_data  <= '0;
      tail    <= '0;
    end else begin
      state   <= state_n;
      m_valid <= (state_n != EMPTY);
      m_data  <= head_n;
      tail    <= tail_n;
    end
  end

endmodule

// File: rtl/fifo_read_port.sv
// FIFO read-side controller: pops storage into the skid buffer and
// strobes decrement to the shared occupancy counter.
module fifo_read_port #(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int DEPTH  = fifo_pkg::DEPTH,
  parameter int PTR_W  = fifo_pkg::PTR_W,
  parameter int CNT_W  = fifo_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  count,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [PTR_W-1:0]  rd_ptr,
  output logic              decrement,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready
);
  import fifo_pkg::*;

  logic pop;
  logic buf_full;

  // Only the registered full flag gates pop, so m_ready never reaches decrement.
  assign pop       = (count != '0) && !buf_full && !reset;
  assign decrement = pop;

  // DEPTH is a power of two, so natural PTR_W overflow wraps the pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  fifo_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_valid (pop),
    .in_data  (mem_rdata),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .full     (buf_full)
  );

endmodule

// File: tb/tb_fifo_read_port.sv
// Directed bench for fifo_read_port with a small storage and counter model.
module tb_fifo_read_port;

  logic       clk;
  logic       reset;
  logic [1:0] count;
  logic [7:0] mem_rdata;
  logic [1:0] rd_ptr;
  logic       decrement;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;

  logic [7:0] mem [4];
  logic       ld;
  logic [1:0] ld_val;
  logic       inc;

  int errors = 0;
  int checks = 0;

  fifo_read_port dut (
    .clk       (clk),
    .reset     (reset),
    .count     (count),
    .mem_rdata (mem_rdata),
    .rd_ptr    (rd_ptr),
    .decrement (decrement),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[rd_ptr];

  // occupancy counter model: load for directed setup, else inc - dec
  always @(posedge clk) begin
    if (ld) count <= ld_val;
    else    count <= count + {1'b0, inc} - {1'b0, decrement};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset   = 1'b1;
    ld      = 1'b1;
    ld_val  = 2'd3;
    inc     = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;

    // reset with count=3
    tick();
    tick();
    check("rst_dec", decrement, 0);
    check("rst_ptr", rd_ptr, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);

    // single word
    mem[0]  = 8'hA5;
    ld_val  = 2'd1;
    m_ready = 1'b1;
    tick();
    reset = 1'b0;
    ld    = 1'b0;
    #1;
    check("sw_dec", decrement, 1);
    tick();
    check("sw_valid", m_valid, 1);
    check("sw_data", m_data, 8'hA5);
    check("sw_ptr", rd_ptr, 1);
    check("sw_dec0", decrement, 0);
    tick();
    check("sw_drain", m_valid, 0);

    // backpressure
    m_ready = 1'b0;
    mem[1]  = 8'h11;
    mem[2]  = 8'h22;
    mem[3]  = 8'h33;
    ld      = 1'b1;
    ld_val  = 2'd3;
    tick();
    ld = 1'b0;
    #1;
    check("bp_pop1", decrement, 1);
    tick();
    check("bp_pop2", decrement, 1);
    tick();
    check("bp_full_dec", decrement, 0);
    check("bp_full_valid", m_valid, 1);
    check("bp_full_data", m_data, 8'h11);
    check("bp_full_ptr", rd_ptr, 3);
    tick();
    check("bp_hold_data", m_data, 8'h11);
    check("bp_hold_dec", decrement, 0);
    check("bp_hold_ptr", rd_ptr, 3);
    m_ready = 1'b1;
    #1;
    check("bp_no_comb", decrement, 0);
    tick();
    check("bp_d22", m_data, 8'h22);
    check("bp_pop3", decrement, 1);
    tick();
    check("bp_d33", m_data, 8'h33);
    check("bp_v33", m_valid, 1);
    check("bp_wrap", rd_ptr, 0);
    check("bp_dec_end", decrement, 0);
    tick();
    check("bp_drain", m_valid, 0);

    // full throughput, writer refilling each popped slot
    for (int i = 0; i < 4; i++) mem[i] = 8'h40 + 8'(i);
    ld     = 1'b1;
    ld_val = 2'd2;
    tick();
    ld  = 1'b0;
    inc = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      check("tp_dec", decrement, 1);
      tick();
      mem[i % 4] = 8'h40 + 8'(i + 4);
      check("tp_valid", m_valid, 1);
      check("tp_data", m_data, 32'h40 + i);
      check("tp_ptr", rd_ptr, (i + 1) % 4);
    end
    inc    = 1'b0;
    ld     = 1'b1;
    ld_val = 2'd0;
    tick();
    ld = 1'b0;
    check("tp_last", m_data, 8'h46);
    check("tp_last_ptr", rd_ptr, 3);
    tick();
    check("tp_drain", m_valid, 0);

    // stall stability
    mem[3]  = 8'h44;
    m_ready = 1'b0;
    ld      = 1'b1;
    ld_val  = 2'd1;
    tick();
    ld = 1'b0;
    tick();
    check("st_valid", m_valid, 1);
    check("st_data", m_data, 8'h44);
    tick();
    check("st_hold1", m_data, 8'h44);
    check("st_vhold1", m_valid, 1);
    tick();
    check("st_hold2", m_data, 8'h44);
    check("st_vhold2", m_valid, 1);
    m_ready = 1'b1;
    tick();
    check("st_accept", m_valid, 0);

    // reset mid-operation
    m_ready = 1'b0;
    mem[0]  = 8'h55;
    mem[1]  = 8'h66;
    ld      = 1'b1;
    ld_val  = 2'd3;
    tick();
    ld = 1'b0;
    tick();
    tick();
    check("mr_full_data", m_data, 8'h55);
    check("mr_full_dec", decrement, 0);
    check("mr_full_ptr", rd_ptr, 2);
    reset = 1'b1;
    tick();
    check("mr_valid", m_valid, 0);
    check("mr_ptr", rd_ptr, 0);
    check("mr_dec", decrement, 0);
    reset  = 1'b0;
    mem[0] = 8'h77;
    #1;
    check("mr_resume_dec", decrement, 1);
    m_ready = 1'b1;
    tick();
    check("mr_resume_valid", m_valid, 1);
    check("mr_resume_data", m_data, 8'h77);
    check("mr_resume_ptr", rd_ptr, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_read_port.md
Name: fifo_read_port

Overview:
Read-side controller for the team's small synchronous FIFO. It consumes entries using the shared occupancy counter's count, addresses FIFO storage through a read pointer, and pulses decrement on every pop. Popped words go into a 2-entry output skid buffer that drives a registered valid/ready stream to the downstream consumer. It is the consumer counterpart of the write-side logic that drives increment.

Parameters:
DATA_W, 8, width of each FIFO word and of m_data
DEPTH, 4, FIFO storage entries; power of 2
PTR_W, 2, log2(DEPTH); width of rd_ptr
CNT_W, 2, width of occupancy count; maximum occupancy is 2**CNT_W-1 = 3

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
count  in  CNT_W  current FIFO occupancy from the occupancy counter (registered)
mem_rdata  in  DATA_W  combinational read of storage[rd_ptr]
rd_ptr  out  PTR_W  storage read address (registered)
decrement  out  1  pop strobe to the occupancy counter; one pulse per entry removed
m_valid  out  1  output word available (registered)
m_data  out  DATA_W  output word (registered, head of skid buffer)
m_ready  in  1  downstream accepts m_data when m_valid=1

Behaviour:
- Reset (reset=1 at a rising edge): rd_ptr=0, buffer state EMPTY, m_valid=0, m_data=0, tail register=0. decrement=0 while reset is high. Reset mid-stream drops any buffered words with no flush handshake. The occupancy counter is reset on the same signal.
- Buffer states:
  - EMPTY: 0 words held.
  - HALF: 1 word held, in head.
  - FULL: 2 words held, head and tail.
  - m_valid=1 in HALF and FULL.
- pop = (count != 0) && (state != FULL) && !reset. decrement = pop, driven combinationally.
- No combinational path from m_ready to decrement. xfer = m_valid && m_ready.
- On pop, mem_rdata is sampled at that edge and rd_ptr <= rd_ptr+1, wrapping modulo DEPTH (3 -> 0).
- count already reflects every previous pop, because the counter registers on the pop edge. No extra in-flight tracking is needed.
- State transitions:
  - EMPTY: pop -> HALF, head<=mem_rdata.
  - HALF, pop and not xfer: -> FULL, tail<=mem_rdata.
  - HALF, pop and xfer: stay HALF, head<=mem_rdata.
  - HALF, not pop and xfer: -> EMPTY.
  - HALF, otherwise: hold.
  - FULL: no pop. xfer -> HALF, head<=tail. Otherwise hold.
- Latency: first entry visible on m_valid/m_data 1 cycle after the pop cycle.
- Throughput: with m_ready held high and count>0, one word per cycle in steady state (HALF, pop and xfer every cycle).
- Stream rule: while m_valid=1 and m_ready=0, m_data and m_valid hold stable. Words leave in exact FIFO order.
- count==0: no pop; the buffer drains normally.
- Integration requirement on the occupancy counter: simultaneous increment and decrement must give net-zero change. This block's pop rule relies on it.
- This block never pops when count==0, so the counter cannot underflow from the read side.

Decomposition:
- Shared package fifo_pkg holds:
  - DATA_W, DEPTH, PTR_W and CNT_W defaults.
  - Buffer state enum: EMPTY=2'd0, HALF=2'd1, FULL=2'd2.
- One natural sub-module: fifo_skid_buf. It holds the 2-entry head/tail registers and state machine, taking in_valid=pop, in_data=mem_rdata, and producing m_valid/m_data/m_ready plus a full flag.
- fifo_read_port keeps pop, decrement and rd_ptr logic and instantiates fifo_skid_buf.

Test Plan:
- Reset: assert reset with count=3 -> decrement=0, rd_ptr=0, m_valid=0, m_data=0.
- Single word: count=1, mem_rdata=8'hA5, m_ready=1.
  - Pop cycle: decrement=1.
  - Next cycle: m_valid=1, m_data=A5, rd_ptr=1.
  - With count then 0: m_valid=0 the following cycle.
- Backpressure: m_ready=0, count=3, storage {11,22,33}.
  - Exactly 2 pops; state FULL; m_data=11; decrement then stays 0.
  - Raise m_ready: output sequence 11,22,33 on consecutive accepted cycles, with a 3rd pop issued once the state leaves FULL.
- Full throughput: m_ready=1, count held at 2 (writer refilling), storage incrementing data.
  - One xfer and one decrement every cycle; m_data increments by 1 each cycle.
  - rd_ptr wraps 3 -> 0 without loss.
- Stall stability: m_valid=1, m_data=44, m_ready toggled 0,0,1 -> m_data stays 44 for 2 cycles; accepted on the 3rd.
- Reset mid-operation: state FULL with {55,66}, assert reset one cycle -> m_valid=0, rd_ptr=0; no decrement during reset; resumes cleanly from count after release.
